// File: rtl/branch_pc_sequencer.sv
// PC owner for the multicycle MIPS datapath: fetch, decode, branch resolution, commit.
// Optional saturating branch statistics counters are enabled with `define BRANCH_STATS_EN.
module branch_pc_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter int unsigned WAIT_LIMIT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_req,
    input  logic        instr_ready,
    input  logic [31:0] instr,
    input  logic        br_valid,
    input  logic        br_taken,
    input  logic [31:0] jr_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        busy,
    output logic        redirect,
    output logic        instr_done,
    output logic        align_err
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0] br_taken_cnt,
    output logic [15:0] br_nottaken_cnt,
    output logic [15:0] br_timeout_cnt
`endif
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_FETCH   = 2'd1;
    localparam logic [1:0] S_DECODE  = 2'd2;
    localparam logic [1:0] S_RESOLVE = 2'd3;

    localparam int unsigned CNT_W = $clog2(WAIT_LIMIT + 1);

    logic [1:0]       state;
    logic [1:0]       nextState;
    logic [31:0]      instrReg;
    logic [31:0]      tgt;
    logic [CNT_W-1:0] waitCnt;
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             isBranch;
    logic             isJump;
    logic             isJr;
    logic             waitExpired;

    assign opcode      = instrReg[31:26];
    assign funct       = instrReg[5:0];
    assign isBranch    = (opcode == 6'h01) || (opcode >= 6'h04 && opcode <= 6'h07);
    assign isJump      = (opcode == 6'h02) || (opcode == 6'h03);
    assign isJr        = (opcode == 6'h00) && (funct == 6'h08 || funct == 6'h09);
    assign waitExpired = (waitCnt == CNT_W'(WAIT_LIMIT - 1));

    always_comb begin
        nextState = state;
        case (state)
            S_IDLE:    if (fetch_req) nextState = S_FETCH;
            S_FETCH:   if (instr_ready) nextState = S_DECODE;
            S_DECODE:  nextState = isBranch ? S_RESOLVE : S_IDLE;
            S_RESOLVE: if (br_valid || waitExpired) nextState = S_IDLE;
            default:   nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            pc         <= RESET_PC;
            pc_plus4   <= RESET_PC + 32'd4;
            redirect   <= 1'b0;
            instr_done <= 1'b0;
            align_err  <= 1'b0;
            instrReg   <= '0;
            tgt        <= '0;
            waitCnt    <= '0;
`ifdef BRANCH_STATS_EN
            br_taken_cnt    <= '0;
            br_nottaken_cnt <= '0;
            br_timeout_cnt  <= '0;
`endif
        end else begin
            state      <= nextState;
            busy       <= (nextState != S_IDLE);
            redirect   <= 1'b0;
            instr_done <= 1'b0;
            align_err  <= 1'b0;
            case (state)
                S_FETCH: begin
                    if (instr_ready) begin
                        instrReg <= instr;
                        pc_plus4 <= pc + 32'd4;
                        tgt      <= pc + 32'd4 + {{14{instr[15]}}, instr[15:0], 2'b00};
                    end
                end
                S_DECODE: begin
                    waitCnt <= '0;
                    if (isJump) begin
                        pc         <= {pc_plus4[31:28], instrReg[25:0], 2'b00};
                        redirect   <= 1'b1;
                        instr_done <= 1'b1;
                    end else if (isJr) begin
                        pc         <= {jr_target[31:2], 2'b00};
                        redirect   <= 1'b1;
                        instr_done <= 1'b1;
                        align_err  <= (jr_target[1:0] != 2'b00);
                    end else if (!isBranch) begin
                        pc         <= pc_plus4;
                        instr_done <= 1'b1;
                    end
                end
                S_RESOLVE: begin
                    // A real verdict wins over the timeout in the same cycle.
                    if (br_valid) begin
                        instr_done <= 1'b1;
                        if (br_taken) begin
                            pc       <= tgt;
                            redirect <= 1'b1;
`ifdef BRANCH_STATS_EN
                            if (br_taken_cnt != 16'hFFFF) br_taken_cnt <= br_taken_cnt + 16'd1;
`endif
                        end else begin
                            pc <= pc_plus4;
`ifdef BRANCH_STATS_EN
                            if (br_nottaken_cnt != 16'hFFFF) br_nottaken_cnt <= br_nottaken_cnt + 16'd1;
`endif
                        end
                    end else if (waitExpired) begin
                        pc         <= pc_plus4;
                        instr_done <= 1'b1;
`ifdef BRANCH_STATS_EN
                        if (br_timeout_cnt != 16'hFFFF) br_timeout_cnt <= br_timeout_cnt + 16'd1;
`endif
                    end else begin
                        waitCnt <= waitCnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_pc_sequencer.sv
// Directed, table-driven bench for branch_pc_sequencer (stats ports follow BRANCH_STATS_EN).
module tb_branch_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_req;
    logic        instr_ready;
    logic [31:0] instr;
    logic        br_valid;
    logic        br_taken;
    logic [31:0] jr_target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        busy;
    logic        redirect;
    logic        instr_done;
    logic        align_err;
`ifdef BRANCH_STATS_EN
    logic [15:0] br_taken_cnt;
    logic [15:0] br_nottaken_cnt;
    logic [15:0] br_timeout_cnt;
`endif

    int nApplied = 0;
    int nMiss    = 0;

    branch_pc_sequencer #(.RESET_PC(32'h0000_3000), .WAIT_LIMIT(16)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .instr_ready(instr_ready),
        .instr(instr), .br_valid(br_valid), .br_taken(br_taken), .jr_target(jr_target),
        .pc(pc), .pc_plus4(pc_plus4), .busy(busy), .redirect(redirect),
        .instr_done(instr_done), .align_err(align_err)
`ifdef BRANCH_STATS_EN
        , .br_taken_cnt(br_taken_cnt), .br_nottaken_cnt(br_nottaken_cnt),
        .br_timeout_cnt(br_timeout_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] jrTarget;
        int          readyDelay;
        int          brDelay;     // resolve cycle index carrying br_valid, -1 = never
        bit          brTaken;
        bit          extraFetch;  // fetch_req pulse while in S_FETCH
        bit          brNoise;     // br_valid=1 during fetch/decode
        int          doneEdge;    // clock edges from fetch_req to commit
        logic [31:0] expPc;
        logic [31:0] expPcPlus4;
        bit          expRedirect;
        bit          expAlign;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nApplied++;
        if (act !== exp) begin
            nMiss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic runVec(input vec_t v, input int idx);
        int  k;
        bit  seen;
        @(negedge clk);
        fetch_req   = 1'b1;
        instr       = v.instr;
        jr_target   = v.jrTarget;
        instr_ready = 1'b0;
        br_valid    = 1'b0;
        br_taken    = 1'b0;
        k = 0;
        seen = 1'b0;
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            if (instr_done) begin
                seen = 1'b1;
            end else begin
                if (k == 1) check($sformatf("v%0d busy_fetch", idx), {31'b0, busy}, 32'd1);
                fetch_req   = v.extraFetch && (k == 1);
                instr_ready = (k + 1 >= 2 + v.readyDelay);
                br_valid    = (v.brNoise && (k + 1 < 4 + v.readyDelay)) ||
                              (v.brDelay >= 0 && (k + 1 == 4 + v.readyDelay + v.brDelay));
                br_taken    = v.brNoise ? 1'b1 : v.brTaken;
            end
        end
        fetch_req   = 1'b0;
        instr_ready = 1'b0;
        br_valid    = 1'b0;
        br_taken    = 1'b0;
        check($sformatf("v%0d done_seen", idx), {31'b0, seen}, 32'd1);
        check($sformatf("v%0d latency", idx), k, v.doneEdge);
        check($sformatf("v%0d pc", idx), pc, v.expPc);
        check($sformatf("v%0d pc_plus4", idx), pc_plus4, v.expPcPlus4);
        check($sformatf("v%0d redirect", idx), {31'b0, redirect}, {31'b0, v.expRedirect});
        check($sformatf("v%0d align_err", idx), {31'b0, align_err}, {31'b0, v.expAlign});
        check($sformatf("v%0d busy_done", idx), {31'b0, busy}, 32'd0);
        @(negedge clk);
        check($sformatf("v%0d pulse_clear", idx), {29'b0, instr_done, redirect, align_err}, 32'd0);
        check($sformatf("v%0d idle_after", idx), {31'b0, busy}, 32'd0);
        check($sformatf("v%0d pc_hold", idx), pc, v.expPc);
    endtask

    initial begin
        vecs[0]  = '{32'h1000FFFF, 32'h0,        0,  1, 1'b1, 1'b0, 1'b0,  5, 32'h0000_3000, 32'h0000_3004, 1'b1, 1'b0}; // BEQ taken
        vecs[1]  = '{32'h14220003, 32'h0,        1,  0, 1'b0, 1'b0, 1'b0,  5, 32'h0000_3004, 32'h0000_3004, 1'b0, 1'b0}; // BNE not taken
        vecs[2]  = '{32'h08000C10, 32'h0,        0, -1, 1'b0, 1'b0, 1'b0,  3, 32'h0000_3040, 32'h0000_3008, 1'b1, 1'b0}; // J
        vecs[3]  = '{32'h03E00008, 32'h00003013, 0, -1, 1'b0, 1'b0, 1'b0,  3, 32'h0000_3010, 32'h0000_3044, 1'b1, 1'b1}; // JR misaligned
        vecs[4]  = '{32'h18400002, 32'h0,        2, -1, 1'b0, 1'b1, 1'b0, 21, 32'h0000_3014, 32'h0000_3014, 1'b0, 1'b0}; // BLEZ timeout
        vecs[5]  = '{32'h1C60FFFC, 32'h0,        1,  0, 1'b1, 1'b0, 1'b1,  5, 32'h0000_3008, 32'h0000_3018, 1'b1, 1'b0}; // BGTZ taken, early noise
        vecs[6]  = '{32'h04010000, 32'h0,        0,  3, 1'b1, 1'b0, 1'b0,  7, 32'h0000_300C, 32'h0000_300C, 1'b1, 1'b0}; // REGIMM imm=0 taken
        vecs[7]  = '{32'h0040F809, 32'hFFFFFFFC, 0, -1, 1'b0, 1'b0, 1'b0,  3, 32'hFFFF_FFFC, 32'h0000_3010, 1'b1, 1'b0}; // JALR aligned
        vecs[8]  = '{32'h00221820, 32'h0,        0, -1, 1'b0, 1'b0, 1'b0,  3, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0}; // ADD, pc wraps
        vecs[9]  = '{32'h8C220004, 32'h0,        0, -1, 1'b0, 1'b0, 1'b0,  3, 32'h0000_0004, 32'h0000_0004, 1'b0, 1'b0}; // LW
        vecs[10] = '{32'h00400008, 32'h0000500A, 0, -1, 1'b0, 1'b0, 1'b0,  3, 32'h0000_5008, 32'h0000_0008, 1'b1, 1'b1}; // JR bit1 set

        rst_n = 1'b0; fetch_req = 1'b0; instr_ready = 1'b0; instr = '0;
        br_valid = 1'b0; br_taken = 1'b0; jr_target = '0;
        repeat (2) @(negedge clk);
        check("rst pc", pc, 32'h0000_3000);
        check("rst pc_plus4", pc_plus4, 32'h0000_3004);
        check("rst busy_pulses", {28'b0, busy, redirect, instr_done, align_err}, 32'd0);
`ifdef BRANCH_STATS_EN
        check("rst stats", {br_taken_cnt, br_nottaken_cnt}, 32'd0);
        check("rst timeout_cnt", {16'b0, br_timeout_cnt}, 32'd0);
`endif
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            runVec(vecs[i], i);
`ifdef BRANCH_STATS_EN
            if (i == 4) begin
                check("stats taken", {16'b0, br_taken_cnt}, 32'd1);
                check("stats nottaken", {16'b0, br_nottaken_cnt}, 32'd1);
                check("stats timeout", {16'b0, br_timeout_cnt}, 32'd1);
            end
`endif
        end
`ifdef BRANCH_STATS_EN
        check("stats taken end", {16'b0, br_taken_cnt}, 32'd3);
`endif

        // Reset while waiting in S_RESOLVE, with a taken verdict on the same edge.
        @(negedge clk);
        fetch_req = 1'b1; instr = 32'h1000FFFF; instr_ready = 1'b1;
        @(negedge clk);
        fetch_req = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst busy_before", {31'b0, busy}, 32'd1);
        rst_n = 1'b0; br_valid = 1'b1; br_taken = 1'b1;
        @(negedge clk);
        check("midrst pc", pc, 32'h0000_3000);
        check("midrst pc_plus4", pc_plus4, 32'h0000_3004);
        check("midrst busy_pulses", {28'b0, busy, redirect, instr_done, align_err}, 32'd0);
`ifdef BRANCH_STATS_EN
        check("midrst stats", {br_taken_cnt, br_nottaken_cnt}, 32'd0);
`endif
        rst_n = 1'b1; br_valid = 1'b0; br_taken = 1'b0; instr_ready = 1'b0;
        @(negedge clk);
        check("midrst stays_idle", {30'b0, busy, instr_done}, 32'd0);
        runVec('{32'h00221820, 32'h0, 0, -1, 1'b0, 1'b0, 1'b0, 3,
                 32'h0000_3004, 32'h0000_3004, 1'b0, 1'b0}, 11);

        $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiss);
        $finish;
    end

endmodule

// File: doc/branch_pc_sequencer.md
Name: branch_pc_sequencer

Overview:
- Consumer side of the branch-condition evaluator in the multicycle MIPS datapath.
- Owns the program counter and sequences fetch, decode and branch resolution.
- Captures the fetched instruction, precomputes the branch/jump target, waits for the evaluator's taken/not-taken verdict, then commits the next PC.
- Sits between instruction memory, the control FSM (fetch_req) and the branch evaluator (br_valid/br_taken).

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- WAIT_LIMIT, 16, maximum cycles spent in S_RESOLVE before a forced fall-through.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- fetch_req  input  1  single-cycle strobe that starts the next instruction; honoured only in S_IDLE.
- instr_ready  input  1  instruction memory data valid.
- instr  input  32  fetched instruction word.
- br_valid  input  1  branch evaluator verdict valid.
- br_taken  input  1  branch evaluator verdict: 1 = taken.
- jr_target  input  32  rs register value, used by JR/JALR.
- pc  output  32  current program counter.
- pc_plus4  output  32  registered pc+4 of the current instruction (link value).
- busy  output  1  high in every state except S_IDLE.
- redirect  output  1  one-cycle pulse when the PC is loaded with a non-sequential target.
- instr_done  output  1  one-cycle pulse on every PC commit.
- align_err  output  1  one-cycle pulse when a JR/JALR target has a nonzero value in bits [1:0].

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - pc=RESET_PC, pc_plus4=RESET_PC+4.
  - redirect=0, instr_done=0, align_err=0.
  - State = S_IDLE.
  - Reset applied in any state aborts the operation in progress, with no commit pulse.
- All outputs are registered. Pulse outputs default to 0 every cycle.
- S_IDLE:
  - fetch_req=1 -> S_FETCH.
  - fetch_req is ignored in every other state. It is not queued.
- S_FETCH:
  - Stays in S_FETCH while instr_ready=0.
  - On instr_ready=1:
    - Latch instr.
    - pc_plus4 <= pc+4, with 32-bit wrap.
    - tgt <= pc+4 + (sign_extend(instr[15:0])<<2), modulo 2^32.
    - Go to S_DECODE.
- S_DECODE (exactly one cycle), dispatch on opcode = instr[31:26]:
  - 01, 04, 05, 06 or 07 (REGIMM, BEQ, BNE, BLEZ, BGTZ) -> S_RESOLVE.
  - 02 or 03 (J, JAL):
    - pc <= {pc_plus4[31:28], instr[25:0], 2'b00}.
    - Pulse redirect and instr_done.
    - Go to S_IDLE.
  - 00 with funct 08 or 09 (JR, JALR):
    - pc <= {jr_target[31:2], 2'b00}.
    - Pulse redirect and instr_done.
    - Also pulse align_err if jr_target[1:0] != 0.
    - Go to S_IDLE.
  - Any other opcode:
    - pc <= pc_plus4.
    - Pulse instr_done. No redirect.
    - Go to S_IDLE.
- S_RESOLVE:
  - Wait counter clears on entry.
  - br_valid=1 and br_taken=1:
    - pc <= tgt.
    - Pulse redirect and instr_done.
    - Go to S_IDLE.
  - br_valid=1 and br_taken=0:
    - pc <= pc_plus4.
    - Pulse instr_done.
    - Go to S_IDLE.
  - Counter reaches WAIT_LIMIT with no br_valid:
    - pc <= pc_plus4.
    - Pulse instr_done.
    - Go to S_IDLE.
  - br_valid is ignored outside S_RESOLVE.
- Latency: a branch commits 1 cycle after br_valid. A jump or non-branch instruction commits at the S_DECODE edge. Minimum total from fetch_req to instr_done is 3 cycles with instr_ready already high.
- A taken branch whose tgt equals pc_plus4 (imm=0) still pulses redirect.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- When defined:
  - Adds outputs br_taken_cnt[15:0], br_nottaken_cnt[15:0] and br_timeout_cnt[15:0].
  - Each counter increments on its commit event.
  - Each counter saturates at 16'hFFFF.
  - All counters clear on reset.
- When undefined: the ports and logic are absent, and behaviour is otherwise identical.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles -> pc=0x3000, pc_plus4=0x3004, busy=0, no pulses.
- BEQ taken:
  - Stimulus: pc=0x3000, instr=0x1000FFFF, br_valid=1 and br_taken=1 on the second cycle in S_RESOLVE.
  - Required response: pc=0x3000, redirect=1, instr_done=1, each for one cycle.
- BNE not taken:
  - Stimulus: pc=0x3000, instr=0x14220003, br_taken=0.
  - Required response: pc=0x3004, redirect=0, instr_done=1.
- J and JR:
  - J: from pc=0x3004, instr=0x08000C10 -> pc=0x3040, redirect=1.
  - JR: instr=0x03E00008, jr_target=0x00003013 -> pc=0x3010, align_err=1.
- Timeout and ignored fetch:
  - Stimulus: BLEZ with no br_valid for 16 cycles in S_RESOLVE; fetch_req pulsed during S_FETCH.
  - Required response: pc=pc_plus4 after the timeout, instr_done=1, and only one instruction processed.
- Reset mid-operation and wrap:
  - Reset asserted in S_RESOLVE -> pc=0x3000, S_IDLE, no instr_done.
  - pc=0xFFFFFFFC with a non-branch instruction -> pc=0x00000000.
  - With BRANCH_STATS_EN defined: after the BEQ, BNE and timeout scenarios, each counter reads 1.
